// File: rtl/add_subtract_unit.sv
// rtl/add_subtract_unit.sv - two-stage pipelined add/subtract unit with carry chaining, accumulator and optional saturation
module add_subtract_unit #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             out_err
);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_RSUB  = 4'b0011;
    localparam logic [3:0] OP_ADC   = 4'b0100;
    localparam logic [3:0] OP_SBB   = 4'b0101;
    localparam logic [3:0] OP_ACC   = 4'b0110;
    localparam logic [3:0] OP_LDACC = 4'b0111;

    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_c;
    logic             r_v;
    logic             r_z;
    logic             r_n;
    logic             r_err;
    logic             r_creg;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_sub;
    logic             w_legal;
    logic             w_ld;
    logic             w_upd_c;
    logic             w_upd_acc;
    logic [WIDTH:0]   w_raw;
    logic             w_raw_v;
    logic [WIDTH-1:0] w_sat_val;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign out_err   = r_err;

    // Every legal op reduces to x + y + cin or x - y - cin on the (W+1)-bit datapath.
    always_comb begin
        w_x       = r_s1_a;
        w_y       = r_s1_b;
        w_cin     = 1'b0;
        w_sub     = 1'b0;
        w_legal   = 1'b1;
        w_ld      = 1'b0;
        w_upd_c   = 1'b1;
        w_upd_acc = 1'b0;
        case (r_s1_op)
            OP_ADD:   ;
            OP_SUB:   w_sub = 1'b1;
            OP_RSUB: begin
                w_sub = 1'b1;
                w_x   = r_s1_b;
                w_y   = r_s1_a;
            end
            OP_ADC:   w_cin = r_creg;
            OP_SBB: begin
                w_sub = 1'b1;
                w_cin = r_creg;
            end
            OP_ACC: begin
                w_x       = r_acc;
                w_y       = r_s1_a;
                w_upd_acc = 1'b1;
            end
            OP_LDACC: begin
                w_ld      = 1'b1;
                w_upd_c   = 1'b0;
                w_upd_acc = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
                w_upd_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        if (w_sub) begin
            w_raw   = {1'b0, w_x} - {1'b0, w_y} - {{WIDTH{1'b0}}, w_cin};
            w_raw_v = (w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_raw[WIDTH-1] != w_x[WIDTH-1]);
        end else begin
            w_raw   = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
            w_raw_v = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_raw[WIDTH-1] != w_x[WIDTH-1]);
        end
    end

    // On overflow the true result shares the sign of x, so clamp toward that sign.
    assign w_sat_val = w_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
        if (w_legal) begin
            if (w_ld) begin
                w_res = r_s1_a;
            end else begin
                w_c   = w_raw[WIDTH];
                w_v   = w_raw_v;
                w_res = (SATURATE && w_raw_v) ? w_sat_val : w_raw[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 4'b0000;
            r_s1_a     <= {WIDTH{1'b0}};
            r_s1_b     <= {WIDTH{1'b0}};
            r_s2_valid <= 1'b0;
            r_out      <= {WIDTH{1'b0}};
            r_c        <= 1'b0;
            r_v        <= 1'b0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_err      <= 1'b0;
            r_creg     <= 1'b0;
            r_acc      <= {WIDTH{1'b0}};
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out <= w_res;
                    r_c   <= w_c;
                    r_v   <= w_v;
                    r_z   <= (w_res == {WIDTH{1'b0}});
                    r_n   <= w_res[WIDTH-1];
                    r_err <= !w_legal;
                    if (w_upd_c) begin
                        r_creg <= w_c;
                    end
                    if (w_upd_acc) begin
                        r_acc <= w_res;
                    end
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_op <= op;
                    r_s1_a  <= ain;
                    r_s1_b  <= bin;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_subtract_unit.sv
// tb/tb_add_subtract_unit.sv - randomized and directed bench for add_subtract_unit, wrap and saturating builds
module tb_add_subtract_unit;

    localparam int W    = 4;
    localparam int M    = 1 << W;
    localparam int MAXS = M / 2 - 1;
    localparam int MINS = -(M / 2);

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic [3:0]   t_op;
    logic [W-1:0] t_ain;
    logic [W-1:0] t_bin;
    logic         out_ready;

    logic         in_ready0, out_valid0, c0, v0, z0, n0, err0;
    logic [W-1:0] out0;
    logic         in_ready1, out_valid1, c1, v1, z1, n1, err1;
    logic [W-1:0] out1;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit rand_rdy = 1'b0;

    int m_creg[2];
    int m_acc[2];
    logic [W+4:0] q0[$];
    logic [W+4:0] q1[$];
    logic [W+4:0] log0[$];
    logic [W+4:0] log1[$];

    add_subtract_unit #(.WIDTH(W), .SATURATE(1'b0)) u_dut_wrap (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .op(t_op), .ain(t_ain), .bin(t_bin), .out_valid(out_valid0), .out_ready(out_ready),
        .out(out0), .flag_c(c0), .flag_v(v0), .flag_z(z0), .flag_n(n0), .out_err(err0)
    );

    add_subtract_unit #(.WIDTH(W), .SATURATE(1'b1)) u_dut_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op(t_op), .ain(t_ain), .bin(t_bin), .out_valid(out_valid1), .out_ready(out_ready),
        .out(out1), .flag_c(c1), .flag_v(v1), .flag_z(z1), .flag_n(n1), .out_err(err1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int u);
        return (u >= M / 2) ? u - M : u;
    endfunction

    // Reference: exact integer arithmetic, then wrap or clamp into W bits.
    task automatic model_step(input int k, input int o, input int a, input int b, output logic [W+4:0] r);
        int tu, ts, res, ci;
        bit legal, bc, bv, upd_c, upd_acc;
        logic [W-1:0] rv;
        ci = m_creg[k];
        legal = 1; upd_c = 1; upd_acc = 0; tu = 0; ts = 0;
        case (o)
            1: begin tu = a + b;          ts = sgn(a) + sgn(b); end
            2: begin tu = a - b;          ts = sgn(a) - sgn(b); end
            3: begin tu = b - a;          ts = sgn(b) - sgn(a); end
            4: begin tu = a + b + ci;     ts = sgn(a) + sgn(b) + ci; end
            5: begin tu = a - b - ci;     ts = sgn(a) - sgn(b) - ci; end
            6: begin tu = m_acc[k] + a;   ts = sgn(m_acc[k]) + sgn(a); upd_acc = 1; end
            7: begin tu = a;              ts = sgn(a); upd_c = 0; upd_acc = 1; end
            default: legal = 0;
        endcase
        bc = (o == 7) ? 1'b0 : ((tu >= M) || (tu < 0));
        bv = (ts > MAXS) || (ts < MINS);
        res = tu % M;
        if (res < 0) res += M;
        if (k == 1 && bv) res = (ts > 0) ? MAXS : M / 2;
        rv = res[W-1:0];
        if (!legal) begin
            r = {1'b1, 4'b0010, {W{1'b0}}};
        end else begin
            r = {1'b0, bc, bv, (res == 0), (res >= M / 2), rv};
            if (upd_c) m_creg[k] = bc;
            if (upd_acc) m_acc[k] = res;
        end
    endtask

    always @(negedge clock) begin
        logic [W+4:0] e0, e1;
        if (reset_n) begin
            if (out_valid0) begin
                if (q0.size() == 0) check_eq("spurious_wrap", out_valid0, 0);
                else check_eq("res_wrap", {err0, c0, v0, z0, n0, out0}, q0[0]);
            end
            if (out_valid1) begin
                if (q1.size() == 0) check_eq("spurious_sat", out_valid1, 0);
                else check_eq("res_sat", {err1, c1, v1, z1, n1, out1}, q1[0]);
            end
            if (out_valid0 && out_ready && q0.size() != 0) begin
                log0.push_back({err0, c0, v0, z0, n0, out0});
                void'(q0.pop_front());
            end
            if (out_valid1 && out_ready && q1.size() != 0) begin
                log1.push_back({err1, c1, v1, z1, n1, out1});
                void'(q1.pop_front());
            end
            if (in_valid && in_ready0) begin
                check_eq("rdy_match", in_ready1, in_ready0);
                model_step(0, t_op, t_ain, t_bin, e0);
                model_step(1, t_op, t_ain, t_bin, e1);
                q0.push_back(e0);
                q1.push_back(e1);
            end
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        logic r;
        n = 0;
        in_valid = 1'b1; t_op = o; t_ain = a; t_bin = b;
        do begin
            @(negedge clock);
            r = in_ready0;
            step();
            n++;
        end while (!r && n < 200);
        if (!r) check_eq("send_timeout", r, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check_eq("drain", (q0.size() == 0 && q1.size() == 0), 1);
    endtask

    task automatic clear_logs;
        log0.delete();
        log1.delete();
    endtask

    initial begin
        int t0, idx;
        logic r;
        logic [3:0] s_op[3];
        logic [W-1:0] s_a[3];
        reset_n = 1'b0; in_valid = 1'b0; t_op = '0; t_ain = '0; t_bin = '0; out_ready = 1'b1;
        m_creg[0] = 0; m_creg[1] = 0; m_acc[0] = 0; m_acc[1] = 0;
        #13;
        check_eq("rst_wrap", {out_valid0, err0, c0, v0, z0, n0, out0}, 0);
        check_eq("rst_sat", {out_valid1, err1, c1, v1, z1, n1, out1}, 0);
        check_eq("rst_rdy", in_ready0, 1);
        step();
        reset_n = 1'b1;
        step();

        clear_logs();
        t0 = cyc;
        send(4'b0001, 4'b1010, 4'b0001);
        send(4'b0001, 4'b1010, 4'b0000);
        send(4'b0001, 4'b1010, 4'b0010);
        send(4'b0001, 4'b1010, 4'b0011);
        check_eq("b2b_cycles", cyc - t0, 4);
        drain();
        check_eq("add_0", log0[0], {5'b00001, 4'b1011});
        check_eq("add_1", log0[1], {5'b00001, 4'b1010});
        check_eq("add_2", log0[2], {5'b00001, 4'b1100});
        check_eq("add_3", log0[3], {5'b00001, 4'b1101});

        send(4'b0001, 4'b0001, 4'b0001);
        check_eq("lat_s1", out_valid0, 0);
        step();
        check_eq("lat_s2", out_valid0, 1);
        drain();

        clear_logs();
        send(4'b0010, 4'b1010, 4'b0011);
        drain();
        check_eq("sub_wrap", log0[0], {5'b00100, 4'b0111});
        check_eq("sub_sat", log1[0], {5'b00101, 4'b1000});

        clear_logs();
        send(4'b0001, 4'b1111, 4'b0001);
        send(4'b0100, 4'b0000, 4'b0000);
        send(4'b0101, 4'b0000, 4'b0001);
        drain();
        check_eq("chain_add", log0[0], {5'b01010, 4'b0000});
        check_eq("chain_adc", log0[1], {5'b00000, 4'b0001});
        check_eq("chain_sbb", log0[2], {5'b01001, 4'b1111});

        clear_logs();
        send(4'b0111, 4'b0011, 4'b0000);
        send(4'b0110, 4'b0100, 4'b0000);
        send(4'b0110, 4'b0100, 4'b0000);
        send(4'b1001, 4'b0101, 4'b0110);
        send(4'b0110, 4'b0001, 4'b0000);
        drain();
        check_eq("acc_ld", log0[0], {5'b00000, 4'b0011});
        check_eq("acc_1", log0[1], {5'b00000, 4'b0111});
        check_eq("acc_2", log0[2], {5'b00101, 4'b1011});
        check_eq("illegal", log0[3], {5'b10010, 4'b0000});
        check_eq("acc_kept", log0[4], {5'b00001, 4'b1100});

        clear_logs();
        s_op = '{4'b0001, 4'b0001, 4'b0001};
        s_a  = '{4'b0001, 4'b0010, 4'b0011};
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; t_op = s_op[0]; t_ain = s_a[0]; t_bin = s_a[0];
        repeat (4) begin
            @(negedge clock);
            r = in_ready0;
            step();
            if (r) begin
                idx++;
                if (idx < 3) begin t_op = s_op[idx]; t_ain = s_a[idx]; t_bin = s_a[idx]; end
            end
        end
        in_valid = 1'b0;
        check_eq("stall_accepts", idx, 2);
        check_eq("stall_rdy", in_ready0, 0);
        check_eq("stall_hold", out0, 4'b0010);
        out_ready = 1'b1;
        send(s_op[2], s_a[2], s_a[2]);
        drain();
        check_eq("stall_cnt", log0.size(), 3);
        check_eq("stall_r0", log0[0], {5'b00000, 4'b0010});
        check_eq("stall_r1", log0[1], {5'b00000, 4'b0100});
        check_eq("stall_r2", log0[2], {5'b00000, 4'b0110});

        out_ready = 1'b0;
        send(4'b0001, 4'b1111, 4'b0001);
        send(4'b0001, 4'b0010, 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_out", {out_valid0, err0, c0, v0, z0, n0, out0}, 0);
        check_eq("rst_mid_rdy", in_ready0, 1);
        q0.delete(); q1.delete();
        m_creg[0] = 0; m_creg[1] = 0; m_acc[0] = 0; m_acc[1] = 0;
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        clear_logs();
        send(4'b0100, 4'b0001, 4'b0001);
        drain();
        check_eq("rst_creg", log0[0], {5'b00000, 4'b0010});

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            send(4'($urandom_range(0, 15)), W'($urandom_range(0, M - 1)), W'($urandom_range(0, M - 1)));
        end
        rand_rdy = 1'b0;
        @(posedge clock);
        #2;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
